ps2_packet_rx: RTL and testbench
================================

PS2_PACKET_RX -- requirements
Module: ps2_packet_rx

Interface
REQ-001 SHALL have parameter SYNC_CHECK, default 1, meaning: 1 = byte 0 of a packet is accepted only if data bit 3 = 1.
REQ-002 SHALL have parameter ERR_W, default 8, meaning: width of the frame-error counter.
REQ-003 SHALL have port mouse_clk  input  1  PS/2 clock from the mouse; all state is updated on its falling edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mouse_data  input  1  PS/2 data line from the mouse.
REQ-006 SHALL have port pkt_ack  input  1  consumer acknowledge for the current packet.
REQ-007 SHALL have port pkt_valid  output  1  a complete packet is held on the packet outputs.
REQ-008 SHALL have port btn  output  3  buttons {middle, right, left} = byte0[2:0].
REQ-009 SHALL have port x_delta  output  9  two's-complement X movement {byte0[4], byte1}.
REQ-010 SHALL have port y_delta  output  9  two's-complement Y movement {byte0[5], byte2}.
REQ-011 SHALL have port ovf  output  2  {y_ovf, x_ovf} = byte0[7:6].
REQ-012 SHALL have port overrun  output  1  sticky flag: a packet was lost before it was acknowledged.
REQ-013 SHALL have port err_count  output  ERR_W  count of discarded frames; saturates at the all-ones value.

Function
REQ-014 SHALL implement frame state machine IDLE -> DATA -> PARITY -> STOP -> IDLE, one mouse_clk falling edge per bit.
REQ-015 IDLE SHALL move to DATA only when mouse_data = 0 (start bit); otherwise it SHALL stay in IDLE.
REQ-016 DATA SHALL shift in 8 bits LSB first, using a 3-bit bit counter, then move to PARITY.
REQ-017 PARITY SHALL sample the parity bit; the frame parity is good when the 8 data bits XOR the parity bit = 1 (odd parity).
REQ-018 STOP SHALL sample the stop bit and return to IDLE; the frame is good when parity is good and the stop bit = 1.
REQ-019 A bad frame SHALL increment err_count (saturating), discard the byte, and reset the byte index to 0.
REQ-020 The byte index SHALL run 0..2.
REQ-021 A good byte SHALL be stored at the current byte index, and the byte index SHALL then advance; after byte 2 it SHALL wrap to 0.
REQ-022 When SYNC_CHECK = 1, a good byte 0 with bit3 = 0 SHALL be discarded, the byte index SHALL stay 0, and err_count SHALL be unchanged.
REQ-023 On the STOP edge completing a good byte 2, btn, x_delta, y_delta and ovf SHALL load from bytes 0-2 and pkt_valid SHALL be 1 after that edge (latency 0 edges after the stop bit).
REQ-024 Packet outputs SHALL hold stable while pkt_valid = 1, except when overwritten per REQ-026.
REQ-025 On an edge with pkt_valid = 1, pkt_ack = 1 and no packet completing, pkt_valid SHALL clear to 0.
REQ-026 On an edge where a packet completes, pkt_valid = 1 and pkt_ack = 0, the new packet SHALL overwrite the outputs, pkt_valid SHALL stay 1, and overrun SHALL set to 1.
REQ-027 On an edge where a packet completes and pkt_ack = 1, the new packet SHALL load, pkt_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-028 pkt_ack SHALL be ignored while pkt_valid = 0.
REQ-029 overrun SHALL clear only on reset.
REQ-030 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-031 While reset = 1, state SHALL be IDLE, bit counter = 0, byte index = 0, and stored bytes = 0.
REQ-032 While reset = 1, outputs SHALL be pkt_valid = 0, btn = 0, x_delta = 0, y_delta = 0, ovf = 0, overrun = 0, err_count = 0.
REQ-033 Reset asserted mid-frame or mid-packet SHALL abandon the partial frame or packet; the first start bit after release SHALL begin byte 0.

Verification
REQ-034 Packet bytes 0x09, 0x05, 0xFD (all good frames) -> btn = 3'b001, x_delta = 9'h005, y_delta = 9'h0FD, ovf = 0, pkt_valid = 1 after the third stop edge.
REQ-035 Byte0 0x38, byte1 0xF0, byte2 0x10 -> x_delta = 9'h1F0 (-16), y_delta = 9'h110, btn = 0; then pkt_ack = 1 for one edge -> pkt_valid = 0.
REQ-036 Byte 1 sent with wrong parity, then a full good packet -> err_count = 1, exactly one packet delivered, carrying the second packet's values.
REQ-037 Two good packets with pkt_ack held 0 -> second packet's values shown, overrun = 1; repeat with pkt_ack = 1 on the completing edge -> overrun stays 0.
REQ-038 SYNC_CHECK = 1: byte 0x00 then packet 0x08, 0x01, 0x02 -> first byte dropped, err_count = 0, packet x_delta = 9'h001, y_delta = 9'h002.
REQ-039 Reset pulse after bit 5 of byte 1, then a full packet 0x0A, 0x03, 0x04 -> pkt_valid = 1 with btn = 3'b010, x_delta = 9'h003, y_delta = 9'h004; 256 bad frames -> err_count = 8'hFF.

Source files
------------

// File: rtl/ps2_packet_rx.sv
// ps2_packet_rx: PS/2 mouse receiver that assembles three 11-bit frames into a movement packet.
// All state advances on the falling edge of the mouse clock.
module ps2_packet_rx #(
    parameter int SYNC_CHECK = 1,
    parameter int ERR_W      = 8
) (
    input  logic             mouse_clk,
    input  logic             reset,
    input  logic             mouse_data,
    input  logic             pkt_ack,
    output logic             pkt_valid,
    output logic [2:0]       btn,
    output logic [8:0]       x_delta,
    output logic [8:0]       y_delta,
    output logic [1:0]       ovf,
    output logic             overrun,
    output logic [ERR_W-1:0] err_count
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_par;
    logic [1:0]       r_byte_idx;
    logic [7:0]       r_byte0;
    logic [7:0]       r_byte1;
    logic             r_pkt_valid;
    logic [2:0]       r_btn;
    logic [8:0]       r_x;
    logic [8:0]       r_y;
    logic [1:0]       r_ovf;
    logic             r_overrun;
    logic [ERR_W-1:0] r_err;
    logic             w_good;
    logic             w_bad;
    logic             w_drop;
    logic             w_store;
    logic             w_done;

    always_ff @(negedge mouse_clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = mouse_data ? IDLE : DATA;
            DATA:    w_next = (r_bit_cnt == 3'd7) ? PARITY : DATA;
            PARITY:  w_next = STOP;
            default: w_next = IDLE;
        endcase
    end

    // Frame verdict is decided on the stop-bit edge using the live stop bit.
    always_comb begin
        w_good  = (r_state == STOP) && mouse_data && (^{r_shift, r_par});
        w_bad   = (r_state == STOP) && !w_good;
        w_drop  = (SYNC_CHECK != 0) && (r_byte_idx == 2'd0) && !r_shift[3];
        w_store = w_good && !w_drop;
        w_done  = w_store && (r_byte_idx == 2'd2);
    end

    always_ff @(negedge mouse_clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_byte_idx  <= '0;
            r_byte0     <= '0;
            r_byte1     <= '0;
            r_pkt_valid <= 1'b0;
            r_btn       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_ovf       <= '0;
            r_overrun   <= 1'b0;
            r_err       <= '0;
        end else begin
            if (r_state == DATA) begin
                r_shift   <= {mouse_data, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (r_state == PARITY) r_par <= mouse_data;
            if (w_bad) begin
                r_byte_idx <= '0;
                if (r_err != {ERR_W{1'b1}}) r_err <= r_err + 1'b1;
            end
            if (w_store) begin
                r_byte_idx <= (r_byte_idx == 2'd2) ? 2'd0 : r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd0) r_byte0 <= r_shift;
                if (r_byte_idx == 2'd1) r_byte1 <= r_shift;
            end
            // Byte 2 is taken straight from the shifter when the packet completes.
            if (w_done) begin
                r_pkt_valid <= 1'b1;
                r_btn       <= r_byte0[2:0];
                r_x         <= {r_byte0[4], r_byte1};
                r_y         <= {r_byte0[5], r_shift};
                r_ovf       <= r_byte0[7:6];
                if (r_pkt_valid && !pkt_ack) r_overrun <= 1'b1;
            end else if (r_pkt_valid && pkt_ack) begin
                r_pkt_valid <= 1'b0;
            end
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign btn       = r_btn;
    assign x_delta   = r_x;
    assign y_delta   = r_y;
    assign ovf       = r_ovf;
    assign overrun   = r_overrun;
    assign err_count = r_err;
endmodule

// File: tb/tb_ps2_packet_rx.sv
// tb_ps2_packet_rx: table-driven packet vectors plus directed error, overrun, sync and reset sequences.
module tb_ps2_packet_rx;
    logic       mouse_clk = 1'b1;
    logic       reset = 1'b1;
    logic       mouse_data = 1'b1;
    logic       pkt_ack = 1'b0;
    logic       pkt_valid;
    logic [2:0] btn;
    logic [8:0] x_delta;
    logic [8:0] y_delta;
    logic [1:0] ovf;
    logic       overrun;
    logic [7:0] err_count;
    int         n_checks = 0;
    int         n_errors = 0;

    ps2_packet_rx #(.SYNC_CHECK(1), .ERR_W(8)) dut (
        .mouse_clk (mouse_clk),
        .reset     (reset),
        .mouse_data(mouse_data),
        .pkt_ack   (pkt_ack),
        .pkt_valid (pkt_valid),
        .btn       (btn),
        .x_delta   (x_delta),
        .y_delta   (y_delta),
        .ovf       (ovf),
        .overrun   (overrun),
        .err_count (err_count)
    );

    always #5 mouse_clk = ~mouse_clk;

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [2:0] btn;
        logic [8:0] x, y;
        logic [1:0] ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Data changes after the rising edge; the DUT samples on the falling edge.
    task automatic send_bit(input logic b);
        @(posedge mouse_clk);
        mouse_data = b;
        @(negedge mouse_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop, input logic ack);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par_ok ? ~^d : ^d);
        @(posedge mouse_clk);
        mouse_data = stop;
        pkt_ack = ack;
        @(negedge mouse_clk);
        #1;
        pkt_ack = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic ack);
        send_frame(a, 1'b1, 1'b1, 1'b0);
        send_frame(b, 1'b1, 1'b1, 1'b0);
        send_frame(c, 1'b1, 1'b1, ack);
    endtask

    task automatic do_reset();
        @(posedge mouse_clk);
        reset = 1'b1;
        mouse_data = 1'b1;
        pkt_ack = 1'b0;
        @(posedge mouse_clk);
        reset = 1'b0;
    endtask

    task automatic ack_edge();
        @(posedge mouse_clk);
        mouse_data = 1'b1;
        pkt_ack = 1'b1;
        @(negedge mouse_clk);
        #1;
        pkt_ack = 1'b0;
    endtask

    task automatic check_pkt(input string tag, input logic [2:0] eb, input logic [8:0] ex,
                             input logic [8:0] ey, input logic [1:0] eo);
        check({tag, " valid"}, 32'(pkt_valid), 32'd1);
        check({tag, " btn"}, 32'(btn), 32'(eb));
        check({tag, " x"}, 32'(x_delta), 32'(ex));
        check({tag, " y"}, 32'(y_delta), 32'(ey));
        check({tag, " ovf"}, 32'(ovf), 32'(eo));
    endtask

    initial begin
        vecs[0] = '{8'h09, 8'h05, 8'hFD, 3'b001, 9'h005, 9'h0FD, 2'b00};
        vecs[1] = '{8'h38, 8'hF0, 8'h10, 3'b000, 9'h1F0, 9'h110, 2'b00};
        vecs[2] = '{8'h08, 8'h01, 8'h02, 3'b000, 9'h001, 9'h002, 2'b00};
        vecs[3] = '{8'h0A, 8'h03, 8'h04, 3'b010, 9'h003, 9'h004, 2'b00};
        vecs[4] = '{8'hC9, 8'h7F, 8'h80, 3'b001, 9'h07F, 9'h080, 2'b11};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFF, 3'b111, 9'h1FF, 9'h1FF, 2'b11};

        #3;
        check("rst valid", 32'(pkt_valid), 32'd0);
        check("rst btn", 32'(btn), 32'd0);
        check("rst x", 32'(x_delta), 32'd0);
        check("rst y", 32'(y_delta), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        check("rst err", 32'(err_count), 32'd0);
        do_reset();

        ack_edge();
        check("ack ignored idle", 32'(pkt_valid), 32'd0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            send_pkt(vecs[v].b0, vecs[v].b1, vecs[v].b2, 1'b0);
            check_pkt($sformatf("vec%0d", v), vecs[v].btn, vecs[v].x, vecs[v].y, vecs[v].ovf);
            send_bit(1'b1);
            #1;
            check($sformatf("vec%0d hold x", v), 32'(x_delta), 32'(vecs[v].x));
            ack_edge();
            check($sformatf("vec%0d acked", v), 32'(pkt_valid), 32'd0);
            check($sformatf("vec%0d err", v), 32'(err_count), 32'd0);
        end

        // Bad parity on byte 1 discards the partial packet.
        do_reset();
        send_frame(8'h0C, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        check("par err count", 32'(err_count), 32'd1);
        send_frame(8'h09, 1'b1, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check("par no early pkt", 32'(pkt_valid), 32'd0);
        send_frame(8'h06, 1'b1, 1'b1, 1'b0);
        check_pkt("par pkt", 3'b001, 9'h007, 9'h006, 2'b00);
        check("par err final", 32'(err_count), 32'd1);

        // Bad stop bit also counts as a frame error.
        send_frame(8'h09, 1'b1, 1'b0, 1'b0);
        check("stop err count", 32'(err_count), 32'd2);

        // Overrun when a second packet lands unacknowledged.
        do_reset();
        send_pkt(8'h09, 8'h05, 8'hFD, 1'b0);
        check("ovr first", 32'(overrun), 32'd0);
        send_pkt(8'h0A, 8'h03, 8'h04, 1'b0);
        check_pkt("ovr pkt2", 3'b010, 9'h003, 9'h004, 2'b00);
        check("ovr set", 32'(overrun), 32'd1);
        ack_edge();
        check("ovr sticky", 32'(overrun), 32'd1);

        do_reset();
        send_pkt(8'h09, 8'h05, 8'hFD, 1'b0);
        send_pkt(8'h0A, 8'h03, 8'h04, 1'b1);
        check_pkt("ack pkt2", 3'b010, 9'h003, 9'h004, 2'b00);
        check("ack no ovr", 32'(overrun), 32'd0);

        // Sync check drops a byte 0 without bit 3.
        do_reset();
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        send_frame(8'h08, 1'b1, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        check("sync no early pkt", 32'(pkt_valid), 32'd0);
        send_frame(8'h02, 1'b1, 1'b1, 1'b0);
        check_pkt("sync pkt", 3'b000, 9'h001, 9'h002, 2'b00);
        check("sync err", 32'(err_count), 32'd0);

        // Asynchronous reset after bit 5 of byte 1 abandons the packet.
        do_reset();
        send_pkt(8'h09, 8'h05, 8'hFD, 1'b0);
        send_frame(8'h09, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async rst valid", 32'(pkt_valid), 32'd0);
        check("async rst x", 32'(x_delta), 32'd0);
        #1;
        reset = 1'b0;
        send_pkt(8'h0A, 8'h03, 8'h04, 1'b0);
        check_pkt("post rst", 3'b010, 9'h003, 9'h004, 2'b00);
        check("post rst err", 32'(err_count), 32'd0);

        // Error counter saturation.
        for (int i = 0; i < 255; i++) send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        check("err 255", 32'(err_count), 32'hFF);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        check("err sat", 32'(err_count), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
